// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor with MSB carry and signed overflow.
module alu_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  assign b_eff = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign sum   = full[WIDTH-1:0];
  assign cout  = full[WIDTH];
  // Carry into the MSB is recovered from the MSB sum bit.
  assign ovf   = (a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1]) ^ cout;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus a WIDTH-cycle
// shift-add multiply that reuses the add/sub unit as its accumulator adder.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             CarryOut
);

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_hi;
  logic [SHW-1:0]   cnt;

  logic             exec;
  logic             accept;
  logic [WIDTH-1:0] add_a, add_b, sum;
  logic             add_sub, cout, ovf;
  logic [WIDTH-1:0] op_res;
  logic             op_ovf, op_cout;
  logic [WIDTH-1:0] prod_hi, prod_lo;

  assign exec     = (state == EXEC);
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // During EXEC the adder accumulates the multiplicand into the high half.
  assign add_a   = exec ? acc_hi : A;
  assign add_b   = exec ? (mplier[0] ? mcand : '0) : B;
  assign add_sub = !exec && (ALUOp != OP_ADD);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (add_a),
    .b    (add_b),
    .sub  (add_sub),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  // Shift {cout, sum, mplier} right by one: the next partial product.
  assign prod_hi = {cout, sum[WIDTH-1:1]};
  assign prod_lo = {sum[0], mplier[WIDTH-1:1]};

  always_comb begin
    op_res  = '0;
    op_ovf  = 1'b0;
    op_cout = 1'b0;
    case (ALUOp)
      OP_AND: op_res = A & B;
      OP_OR:  op_res = A | B;
      OP_ADD, OP_SUB: begin
        op_res  = sum;
        op_ovf  = ovf;
        op_cout = cout;
      end
      OP_SLT: op_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      OP_SLL: op_res = A << B[SHW-1:0];
      OP_SRL: op_res = A >> B[SHW-1:0];
      default: op_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      Result    <= '0;
      Zero      <= 1'b0;
      Overflow  <= 1'b0;
      CarryOut  <= 1'b0;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc_hi    <= '0;
    end else begin
      if ((state == DONE) && out_ready) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end
      if (exec) begin
        acc_hi <= prod_hi;
        mplier <= prod_lo;
        cnt    <= cnt + SHW'(1);
        if (cnt == SHW'(WIDTH - 1)) begin
          state     <= DONE;
          out_valid <= 1'b1;
          Result    <= prod_lo;
          Zero      <= (prod_lo == '0);
          Overflow  <= |prod_hi;
          CarryOut  <= 1'b0;
          cnt       <= '0;
        end
      end else if (accept) begin
        if (ALUOp == OP_MUL) begin
          state  <= EXEC;
          mcand  <= A;
          mplier <= B;
          acc_hi <= '0;
          cnt    <= '0;
        end else begin
          state     <= DONE;
          out_valid <= 1'b1;
          Result    <= op_res;
          Zero      <= (op_res == '0);
          Overflow  <= op_ovf;
          CarryOut  <= op_cout;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH = 16, 8 and 32 running side by side.
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        c;
  } exp_t;

  logic clk = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_w
    localparam int W = (gi == 0) ? 16 : ((gi == 1) ? 8 : 32);
    localparam logic [W-1:0] MAXPOS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINNEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONES   = {W{1'b1}};
    localparam logic [W-1:0] PAT_C  = {(W/4){4'hC}};
    localparam logic [W-1:0] PAT_A  = {(W/4){4'hA}};
    localparam logic [W-1:0] PAT_8  = {(W/4){4'h8}};
    localparam logic [W-1:0] PAT_E  = {(W/4){4'hE}};
    localparam logic [W-1:0] HALF   = W'(1) << (W/2);

    logic         rst = 1'b1;
    logic         iv = 1'b0;
    logic         ordy = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = 3'b000;
    logic         irdy, ov, z, o, c;
    logic [W-1:0] res;
    logic         done = 1'b0;
    exp_t         q[$];

    alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (rst),
      .in_valid  (iv),
      .in_ready  (irdy),
      .A         (a),
      .B         (b),
      .ALUOp     (op),
      .out_valid (ov),
      .out_ready (ordy),
      .Result    (res),
      .Zero      (z),
      .Overflow  (o),
      .CarryOut  (c)
    );

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [2:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input logic [W-1:0] er, input logic ez, input logic eo, input logic ec);
      exp_t e;
      int   n;
      iv = 1'b1; op = op_i; a = a_i; b = b_i;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!irdy && n < 200);
      if (!irdy) check($sformatf("W%0d accept timeout", W), 64'(irdy), 64'(1));
      e.res = 32'(er); e.z = ez; e.o = eo; e.c = ec;
      q.push_back(e);
      @(posedge clk);
      #1 iv = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid; ends on a negedge.
    task automatic wait_out(output int lat, output logic saw_ready);
      lat = 0;
      saw_ready = 1'b0;
      @(negedge clk);
      while (!ov && lat < 200) begin
        saw_ready = saw_ready | irdy;
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    endtask

    initial begin : monitor
      exp_t e;
      forever begin
        @(negedge clk);
        if (!rst && ov && ordy) begin
          if (q.size() == 0) begin
            check($sformatf("W%0d unexpected result", W), 64'(res), 64'(0) - 64'(1));
          end else begin
            e = q.pop_front();
            check($sformatf("W%0d result/z/o/c", W), {29'b0, 32'(res), z, o, c},
                  {29'b0, e.res, e.z, e.o, e.c});
          end
        end
      end
    end

    initial begin : stim
      int   lat;
      logic saw;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check($sformatf("W%0d reset outputs", W), {59'b0, ov, z, o, c, irdy}, 64'b1);
      check($sformatf("W%0d reset Result", W), 64'(res), 64'(0));
      @(posedge clk);
      #1;

      send(OP_ADD, MAXPOS, W'(1), MINNEG, 1'b0, 1'b1, 1'b0);
      wait_out(lat, saw);
      check($sformatf("W%0d add latency", W), 64'(lat), 64'(0));
      @(posedge clk); #1;
      send(OP_SUB, W'(5), W'(5), '0, 1'b1, 1'b0, 1'b1);
      send(OP_SLT, ONES, W'(1), W'(1), 1'b0, 1'b0, 1'b0);
      send(OP_SLL, W'(1), W'(W + 3), W'(8), 1'b0, 1'b0, 1'b0);
      send(OP_SRL, MINNEG, W'(W - 1), W'(1), 1'b0, 1'b0, 1'b0);
      send(OP_AND, PAT_C, PAT_A, PAT_8, 1'b0, 1'b0, 1'b0);
      send(OP_OR, PAT_C, PAT_A, PAT_E, 1'b0, 1'b0, 1'b0);
      wait_out(lat, saw);
      check($sformatf("W%0d back-to-back latency", W), 64'(lat), 64'(0));
      @(posedge clk); #1;

      send(OP_MUL, HALF, HALF, '0, 1'b1, 1'b1, 1'b0);
      wait_out(lat, saw);
      check($sformatf("W%0d mul latency", W), 64'(lat), 64'(W));
      check($sformatf("W%0d in_ready in EXEC", W), 64'(saw), 64'(0));
      @(posedge clk); #1;
      send(OP_MUL, W'(8'hFF), W'(3), (W == 8) ? W'(8'hFD) : W'(12'h2FD),
           1'b0, (W == 8), 1'b0);
      wait_out(lat, saw);
      check($sformatf("W%0d mul2 latency", W), 64'(lat), 64'(W));
      @(posedge clk); #1;

      ordy = 1'b0;
      send(OP_ADD, W'(3), W'(4), W'(7), 1'b0, 1'b0, 1'b0);
      wait_out(lat, saw);
      for (int k = 0; k < 3; k++) begin
        @(posedge clk);
        @(negedge clk);
        check($sformatf("W%0d stall %0d ov/z/o/c/irdy", W, k), {59'b0, ov, z, o, c, irdy}, 64'b10000);
        check($sformatf("W%0d stall %0d Result", W, k), 64'(res), 64'(7));
      end
      @(posedge clk); #1;
      ordy = 1'b1;
      send(OP_OR, W'(8'h30), W'(8'h05), W'(8'h35), 1'b0, 1'b0, 1'b0);
      wait_out(lat, saw);
      check($sformatf("W%0d or after stall latency", W), 64'(lat), 64'(0));
      @(posedge clk); #1;

      send(OP_MUL, W'(3), W'(5), W'(15), 1'b0, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check($sformatf("W%0d abort outputs", W), {59'b0, ov, z, o, c, irdy}, 64'b1);
      check($sformatf("W%0d abort Result", W), 64'(res), 64'(0));
      saw = 1'b0;
      for (int k = 0; k < W + 4; k++) begin
        @(negedge clk);
        saw = saw | ov;
      end
      check($sformatf("W%0d aborted product shown", W), 64'(saw), 64'(0));
      @(posedge clk); #1;

      send(OP_ADD, W'(1), W'(1), W'(2), 1'b0, 1'b0, 1'b0);
      wait_out(lat, saw);
      @(posedge clk); #1;
      check($sformatf("W%0d scoreboard drained", W), 64'(q.size()), 64'(0));
      done = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && !(g_w[0].done && g_w[1].done && g_w[2].done); i++)
      @(posedge clk);
    if (!(g_w[0].done && g_w[1].done && g_w[2].done))
      check("global timeout", 64'(0), 64'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 16-bit ripple ALU. It keeps the AND/OR/ADD/SUB core and zero/carry/overflow flags, and adds signed set-less-than, logical shifts and a multi-cycle shift-add multiply. Operands enter through a valid/ready input port; results and flags are registered and held on a valid/ready output port. The block sits between the register-file read stage and writeback of the CPU datapath, so the control unit can stall on multiply.

## Interface
- WIDTH, 16, operand/result width; must be a power of two, ≥ 4
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset synchronous and active-high
- in_valid  in  1  operand/op presented
- in_ready  out  1  block accepts operands this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B (shift amount = B[SHW-1:0])
- ALUOp  in  3  operation select
- out_valid  out  1  Result/flags valid
- out_ready  in  1  consumer takes result
- Result  out  WIDTH  registered result
- Zero  out  1  Result == 0
- Overflow  out  1  signed overflow (ADD/SUB) or product truncation (MUL)
- CarryOut  out  1  carry out of MSB (ADD/SUB)

## Operation
- ALUOp: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 SLL, 110 SRL, 111 MUL.
- Accept: in_valid && in_ready at a rising edge. A, B and ALUOp are captured internally, so inputs may change after acceptance.
- in_ready = (state == IDLE) || (state == DONE && out_ready). This gives back-to-back throughput of one op per cycle for single-cycle ops.
- States:
  - IDLE: wait for accept.
    - Non-MUL op → DONE.
    - MUL → EXEC.
  - EXEC: one shift-add iteration per cycle on an iteration counter (0..WIDTH-1).
    - After the final iteration → DONE.
  - DONE: out_valid = 1; Result and flags held stable.
    - out_ready=1 with a new accept → DONE (non-MUL) or EXEC (MUL).
    - out_ready=1 with no accept → IDLE.
- ADD: A+B.
- SUB: A+~B+1.
- CarryOut for ADD/SUB: the MSB carry. For SUB, CarryOut=1 means no borrow.
- Overflow for ADD/SUB: carry into MSB XOR carry out of MSB.
- SLT: Result = {0…, (A <s B)}, using the sign of A−B XOR the SUB overflow. CarryOut=0, Overflow=0.
- SLL/SRL: shift by B[SHW-1:0]; upper bits of B are ignored. Zero fill. CarryOut=0, Overflow=0.
- MUL (unsigned): Result = low WIDTH bits of A*B. Overflow = 1 iff any high product bit ≠ 0. CarryOut=0.
- AND/OR: CarryOut=0, Overflow=0.
- Zero is computed from the final Result for every op.

## Timing
- Reset values: out_valid=0, Result=0, Zero=0, Overflow=0, CarryOut=0, state=IDLE, counter=0. in_ready=1 in the cycle after reset deasserts.
- Reset has priority over every other event. Reset during EXEC or DONE aborts the op; the pending result is discarded and never presented.
- Single-cycle ops: accepted at edge N → out_valid=1 after edge N.
- MUL: accepted at edge N → EXEC for WIDTH cycles → out_valid=1 after edge N+WIDTH. in_ready=0 throughout EXEC.
- Backpressure: while out_valid && !out_ready, Result, flags and out_valid are frozen and in_ready=0.
- Simultaneous out_ready with in_valid in DONE: the old result retires and the new op is accepted on the same edge. No bubble for single-cycle ops.
- Outputs are driven only from registers. The only combinational input→output path is out_ready → in_ready.

## Structure
- Package alu_pkg holds:
  - the ALUOp localparams (OP_AND … OP_MUL);
  - the state enum {IDLE, EXEC, DONE}.
- Sub-module alu_addsub (combinational, WIDTH-parametrised):
  - inputs a, b, sub;
  - outputs sum, cout, ovf;
  - shared by ADD, SUB and SLT, and reused as the MUL accumulator adder.
- Top level holds the FSM, operand/partial-product registers, iteration counter, shifter and output registers.

## Test plan
- ADD 0x7FFF+0x0001 (WIDTH=16) → Result 0x8000, Overflow=1, CarryOut=0, Zero=0, out_valid one cycle after accept.
- SUB 0x0005−0x0005 → Result 0x0000, Zero=1, CarryOut=1, Overflow=0. SLT 0xFFFF vs 0x0001 → Result 0x0001.
- SLL 0x0001 by B=0x0013 → shift 3, Result 0x0008. SRL 0x8000 by 15 → 0x0001.
- MUL 0x0100×0x0100 → Result 0x0000, Zero=1, Overflow=1, out_valid exactly 16 cycles after accept, in_ready=0 during EXEC. MUL 0x00FF×0x0003 → 0x02FD, Overflow=0.
- Backpressure: hold out_ready=0 for 3 cycles after ADD completes → Result, flags and out_valid stable, in_ready=0. Then out_ready=1 together with in_valid (OR) → OR result valid on the next cycle.
- Reset asserted at cycle 5 of a MUL → next edge out_valid=0, all outputs 0, in_ready=1. The aborted product is never presented.
- Repeat all scenarios with WIDTH=8 and WIDTH=32 (MUL latency equals WIDTH).
